// File: rtl/k_and_s_pkg.sv
// rtl/k_and_s_pkg.sv - shared types and constants for the K&S datapath
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_BRANCH,
        I_BZERO,
        I_BNEG,
        I_BOV,
        I_BNOV,
        I_BNNEG,
        I_HALT
    } decoded_instruction_type;

    localparam logic [7:0] OP_LOAD   = 8'h81;
    localparam logic [7:0] OP_STORE  = 8'h82;
    localparam logic [7:0] OP_MOVE   = 8'h91;
    localparam logic [7:0] OP_ADD    = 8'hA1;
    localparam logic [7:0] OP_SUB    = 8'hA2;
    localparam logic [7:0] OP_AND    = 8'hA3;
    localparam logic [7:0] OP_OR     = 8'hA4;
    localparam logic [7:0] OP_BRANCH = 8'h01;
    localparam logic [7:0] OP_BZERO  = 8'h02;
    localparam logic [7:0] OP_BNEG   = 8'h03;
    localparam logic [7:0] OP_BOV    = 8'h05;
    localparam logic [7:0] OP_BNOV   = 8'h06;
    localparam logic [7:0] OP_BNNEG  = 8'h0A;
    localparam logic [7:0] OP_HALT   = 8'hFF;

    localparam logic [1:0] ALU_OR  = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } mem_state_t;

endpackage

// File: rtl/ks_data_path_mem_if.sv
// rtl/ks_data_path_mem_if.sv - req/ack program/data RAM bus
interface ks_data_path_mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_req;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_ack;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output ram_addr, ram_req, ram_we, ram_wdata,
        input  ram_ack, ram_rdata
    );

    modport slave (
        input  ram_addr, ram_req, ram_we, ram_wdata,
        output ram_ack, ram_rdata
    );
endinterface

// File: rtl/ks_mem_seq.sv
// rtl/ks_mem_seq.sv - memory handshake sequencer with latched access and read buffer
module ks_mem_seq
    import k_and_s_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_start,
    input  logic                mem_write,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [DATA_W-1:0]   start_wdata,
    output logic                mem_busy,
    output logic                mem_done,
    output logic [DATA_W-1:0]   rd_buf,
    ks_data_path_mem_if.master  ram
);
    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_buf_q, rd_buf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rd_buf_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rd_buf_q <= rd_buf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rd_buf_d = rd_buf_q;
        case (state_q)
            IDLE: begin
                if (mem_start) begin
                    addr_d  = start_addr;
                    we_d    = mem_write;
                    wdata_d = start_wdata;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ram.ram_ack) begin
                    if (!we_q) begin
                        rd_buf_d = ram.ram_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write qualifier is gated so it can never be seen without a live request.
    assign ram.ram_req   = (state_q == REQ);
    assign ram.ram_we    = we_q & (state_q == REQ);
    assign ram.ram_addr  = addr_q;
    assign ram.ram_wdata = wdata_q;
    assign mem_busy      = (state_q != IDLE);
    assign mem_done      = (state_q == DONE);
    assign rd_buf        = rd_buf_q;
endmodule

// File: rtl/ks_data_path_mem.sv
// rtl/ks_data_path_mem.sv - K&S datapath: PC, IR, register file, ALU, flags, decoder
module ks_data_path_mem
    import k_and_s_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic                    write_reg_enable,
    input  logic                    flags_reg_enable,
    input  logic [1:0]              operation,
    input  logic                    mem_start,
    input  logic                    mem_write,
    output logic                    mem_busy,
    output logic                    mem_done,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    ks_data_path_mem_if.master      ram
);
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];
    logic              zero_q, zero_d, neg_q, neg_d, uov_q, uov_d, sov_q, sov_d;

    decoded_instruction_type dec;
    logic [1:0]        a_sel, b_sel, dst_sel, src_sel;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] rd_buf, alu_a, alu_b, alu_r;
    logic [DATA_W:0]   alu_sum;
    logic              alu_uov, alu_sov;
    logic              unused_ir;

    assign unused_ir = ^{ir_q[7], ir_q[4]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= '0;
            ir_q   <= '0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            uov_q  <= 1'b0;
            sov_q  <= 1'b0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
            uov_q  <= uov_d;
            sov_q  <= sov_d;
            regs_q <= regs_d;
        end
    end

    always_comb begin
        dec     = I_NOP;
        a_sel   = '0;
        b_sel   = '0;
        dst_sel = '0;
        src_sel = '0;
        m_addr  = '0;
        case (ir_q[15:8])
            OP_LOAD:  begin dec = I_LOAD;  dst_sel = ir_q[6:5]; m_addr = ir_q[ADDR_W-1:0]; end
            OP_STORE: begin dec = I_STORE; src_sel = ir_q[6:5]; m_addr = ir_q[ADDR_W-1:0]; end
            OP_MOVE:  begin dec = I_MOVE;  dst_sel = ir_q[3:2]; a_sel = ir_q[1:0]; b_sel = ir_q[1:0]; end
            OP_ADD:   begin dec = I_ADD; a_sel = ir_q[1:0]; b_sel = ir_q[3:2]; dst_sel = ir_q[3:2]; end
            OP_SUB:   begin dec = I_SUB; a_sel = ir_q[1:0]; b_sel = ir_q[3:2]; dst_sel = ir_q[3:2]; end
            OP_AND:   begin dec = I_AND; a_sel = ir_q[1:0]; b_sel = ir_q[3:2]; dst_sel = ir_q[3:2]; end
            OP_OR:    begin dec = I_OR;  a_sel = ir_q[1:0]; b_sel = ir_q[3:2]; dst_sel = ir_q[3:2]; end
            OP_BRANCH: begin dec = I_BRANCH; m_addr = ir_q[ADDR_W-1:0]; end
            OP_BZERO:  begin dec = I_BZERO;  m_addr = ir_q[ADDR_W-1:0]; end
            OP_BNEG:   begin dec = I_BNEG;   m_addr = ir_q[ADDR_W-1:0]; end
            OP_BOV:    begin dec = I_BOV;    m_addr = ir_q[ADDR_W-1:0]; end
            OP_BNOV:   begin dec = I_BNOV;   m_addr = ir_q[ADDR_W-1:0]; end
            OP_BNNEG:  begin dec = I_BNNEG;  m_addr = ir_q[ADDR_W-1:0]; end
            OP_HALT:   dec = I_HALT;
            default:   dec = I_NOP;
        endcase
    end

    assign alu_a = regs_q[a_sel];
    assign alu_b = regs_q[b_sel];

    // Operand order is b op a: SUB computes b-a and borrows when b<a.
    always_comb begin
        alu_sum = '0;
        alu_r   = '0;
        alu_uov = 1'b0;
        alu_sov = 1'b0;
        case (operation)
            ALU_ADD: begin
                alu_sum = {1'b0, alu_b} + {1'b0, alu_a};
                alu_r   = alu_sum[DATA_W-1:0];
                alu_uov = alu_sum[DATA_W];
                alu_sov = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) && (alu_r[DATA_W-1] != alu_a[DATA_W-1]);
            end
            ALU_SUB: begin
                alu_r   = alu_b - alu_a;
                alu_uov = (alu_b < alu_a);
                alu_sov = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) && (alu_r[DATA_W-1] != alu_b[DATA_W-1]);
            end
            ALU_AND: alu_r = alu_b & alu_a;
            default: alu_r = alu_b | alu_a;
        endcase
    end

    always_comb begin
        pc_d   = pc_q;
        ir_d   = ir_q;
        regs_d = regs_q;
        zero_d = zero_q;
        neg_d  = neg_q;
        uov_d  = uov_q;
        sov_d  = sov_q;
        if (pc_enable) begin
            pc_d = branch ? m_addr : pc_q + ADDR_W'(1);
        end
        if (ir_enable) begin
            ir_d = rd_buf[15:0];
        end
        if (write_reg_enable) begin
            regs_d[dst_sel] = c_sel ? alu_r : rd_buf;
        end
        if (flags_reg_enable) begin
            zero_d = (alu_r == '0);
            neg_d  = alu_r[DATA_W-1];
            uov_d  = alu_uov;
            sov_d  = alu_sov;
        end
    end

    // pc_q is the pre-update value, so a same-cycle pc_enable does not move the access.
    ks_mem_seq #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_start   (mem_start),
        .mem_write   (mem_write),
        .start_addr  (addr_sel ? m_addr : pc_q),
        .start_wdata (regs_q[src_sel]),
        .mem_busy    (mem_busy),
        .mem_done    (mem_done),
        .rd_buf      (rd_buf),
        .ram         (ram)
    );

    assign decoded_instruction = dec;
    assign zero_op             = zero_q;
    assign neg_op              = neg_q;
    assign unsigned_overflow   = uov_q;
    assign signed_overflow     = sov_q;
endmodule

// File: tb/tb_ks_data_path_mem.sv
// tb/tb_ks_data_path_mem.sv - bench for ks_data_path_mem at 16/5 and 32/3 widths
module tb_ks_data_path_mem;
    import k_and_s_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, branch, pc_enable, ir_enable, addr_sel, c_sel;
    logic write_reg_enable, flags_reg_enable, mem_start, mem_write;
    logic [1:0] operation;
    logic ack_drv;
    logic [63:0] rd_val;

    logic busy16, done16, z16, n16, u16f, s16;
    logic busy32, done32, z32, n32, u32f, s32;
    decoded_instruction_type dec16, dec32;

    ks_data_path_mem_if #(.DATA_W(16), .ADDR_W(5)) ram16 ();
    ks_data_path_mem_if #(.DATA_W(32), .ADDR_W(3)) ram32 ();
    assign ram16.ram_ack   = ack_drv;
    assign ram32.ram_ack   = ack_drv;
    assign ram16.ram_rdata = rd_val[15:0];
    assign ram32.ram_rdata = rd_val[31:0];

    ks_data_path_mem #(.DATA_W(16), .ADDR_W(5)) u16 (
        .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
        .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
        .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
        .operation(operation), .mem_start(mem_start), .mem_write(mem_write),
        .mem_busy(busy16), .mem_done(done16), .decoded_instruction(dec16),
        .zero_op(z16), .neg_op(n16), .unsigned_overflow(u16f), .signed_overflow(s16),
        .ram(ram16)
    );

    ks_data_path_mem #(.DATA_W(32), .ADDR_W(3)) u32 (
        .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
        .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
        .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
        .operation(operation), .mem_start(mem_start), .mem_write(mem_write),
        .mem_busy(busy32), .mem_done(done32), .decoded_instruction(dec32),
        .zero_op(z32), .neg_op(n32), .unsigned_overflow(u32f), .signed_overflow(s32),
        .ram(ram32)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] sb16 [$];
    logic [63:0] sb32 [$];

    typedef struct {
        logic [7:0]  opc;
        logic [1:0]  op;
        logic [63:0] a, b, r16, r32;
        logic        z, n, u, s;
        decoded_instruction_type dec;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_access(input logic we, input logic asel, input logic [63:0] rdata,
                             input int lat, input logic pc_too, input logic restart,
                             output int req_cycles, output logic [63:0] a16, output logic [63:0] a32);
        int n;
        int done_cnt;
        logic [63:0] e16, e32;
        e16 = '0;
        e32 = '0;
        a16 = '0;
        a32 = '0;
        req_cycles = 0;
        if (we && sb16.size() > 0 && sb32.size() > 0) begin
            e16 = sb16.pop_front();
            e32 = sb32.pop_front();
        end
        mem_start = 1'b1; mem_write = we; addr_sel = asel; pc_enable = pc_too; branch = 1'b0;
        @(negedge clk);
        mem_start = 1'b0; pc_enable = 1'b0;
        n = 0;
        while (!ram16.ram_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("req_rise", 64'(ram16.ram_req), 64'h1);
        for (int i = 1; i <= lat; i++) begin
            if (ram16.ram_req) req_cycles++;
            if (i == 1) begin
                a16 = 64'(ram16.ram_addr);
                a32 = 64'(ram32.ram_addr);
            end
            if (we) begin
                chk("store_we", 64'(ram16.ram_we), 64'h1);
                chk("store_wdata16", 64'(ram16.ram_wdata), e16);
                chk("store_wdata32", 64'(ram32.ram_wdata), e32);
            end
            mem_start = restart && (i == 1);
            if (i == lat) begin
                ack_drv = 1'b1;
                rd_val  = rdata;
            end
            @(negedge clk);
        end
        ack_drv = 1'b0; rd_val = '0; mem_start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (done16) done_cnt++;
            chk("req_low_after", 64'(ram16.ram_req), 64'h0);
            chk("we_low_after", 64'(ram16.ram_we), 64'h0);
            @(negedge clk);
        end
        chk("mem_done_pulses", 64'(done_cnt), 64'h1);
    endtask

    task automatic acc(input logic we, input logic asel, input logic [63:0] rdata);
        int rc;
        logic [63:0] x16, x32;
        do_access(we, asel, rdata, 2, 1'b0, 1'b0, rc, x16, x32);
    endtask

    task automatic pulse_ir();
        ir_enable = 1'b1;
        @(negedge clk);
        ir_enable = 1'b0;
    endtask

    task automatic pulse_pc(input logic br);
        pc_enable = 1'b1; branch = br;
        @(negedge clk);
        pc_enable = 1'b0; branch = 1'b0;
    endtask

    task automatic load_ir(input logic [15:0] instr);
        acc(1'b0, 1'b0, 64'(instr));
        pulse_ir();
    endtask

    task automatic set_reg(input logic [1:0] r, input logic [63:0] v);
        load_ir({8'h81, 1'b0, r, 5'h00});
        acc(1'b0, 1'b1, v);
        write_reg_enable = 1'b1; c_sel = 1'b0;
        @(negedge clk);
        write_reg_enable = 1'b0;
    endtask

    task automatic get_reg(input logic [1:0] r, input logic [63:0] e16, input logic [63:0] e32);
        load_ir({8'h82, 1'b0, r, 5'h00});
        sb16.push_back(e16);
        sb32.push_back(e32);
        acc(1'b1, 1'b1, 64'h0);
    endtask

    task automatic alu_exec(input logic [1:0] op);
        operation = op; write_reg_enable = 1'b1; c_sel = 1'b1; flags_reg_enable = 1'b1;
        @(negedge clk);
        write_reg_enable = 1'b0; c_sel = 1'b0; flags_reg_enable = 1'b0; operation = 2'b00;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rc;
        logic [63:0] a16, a32;

        vecs[0] = '{OP_ADD, ALU_ADD, 64'h0001, 64'h7FFF, 64'h8000, 64'h8000,     1'b0, 1'b1, 1'b0, 1'b1, I_ADD};
        vecs[1] = '{OP_SUB, ALU_SUB, 64'h0001, 64'h0000, 64'hFFFF, 64'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, I_SUB};
        vecs[2] = '{OP_ADD, ALU_ADD, 64'hFFFF, 64'h0001, 64'h0000, 64'h10000,    1'b1, 1'b0, 1'b1, 1'b0, I_ADD};
        vecs[3] = '{OP_SUB, ALU_SUB, 64'h0001, 64'h8000, 64'h7FFF, 64'h7FFF,     1'b0, 1'b0, 1'b0, 1'b1, I_SUB};
        vecs[4] = '{OP_AND, ALU_AND, 64'hF0F0, 64'hFF00, 64'hF000, 64'hF000,     1'b0, 1'b1, 1'b0, 1'b0, I_AND};
        vecs[5] = '{OP_OR,  ALU_OR,  64'h00F0, 64'h0F00, 64'h0FF0, 64'h0FF0,     1'b0, 1'b0, 1'b0, 1'b0, I_OR};
        vecs[6] = '{OP_SUB, ALU_SUB, 64'h0005, 64'h0005, 64'h0000, 64'h0000,     1'b1, 1'b0, 1'b0, 1'b0, I_SUB};

        rst_n = 1'b0; branch = 1'b0; pc_enable = 1'b0; ir_enable = 1'b0; addr_sel = 1'b0;
        c_sel = 1'b0; write_reg_enable = 1'b0; flags_reg_enable = 1'b0; operation = 2'b00;
        mem_start = 1'b0; mem_write = 1'b0; ack_drv = 1'b0; rd_val = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_req", 64'(ram16.ram_req), 64'h0);
        chk("rst_we", 64'(ram16.ram_we), 64'h0);
        chk("rst_done", 64'(done16), 64'h0);
        chk("rst_busy", 64'(busy16), 64'h0);
        chk("rst_addr", 64'(ram16.ram_addr), 64'h0);
        chk("rst_wdata", 64'(ram16.ram_wdata), 64'h0);
        chk("rst_flags", 64'({z16, n16, u16f, s16}), 64'h0);
        chk("rst_dec", 64'(dec16), 64'(I_NOP));

        // Fetch with a three-cycle RAM latency
        do_access(1'b0, 1'b0, 64'hA104, 3, 1'b0, 1'b0, rc, a16, a32);
        chk("fetch_addr", a16, 64'h0);
        chk("fetch_req_cycles", 64'(rc), 64'h3);
        pulse_ir();
        chk("fetch_dec16", 64'(dec16), 64'(I_ADD));
        chk("fetch_dec32", 64'(dec32), 64'(I_ADD));

        for (int i = 0; i < 7; i++) begin
            set_reg(2'd1, vecs[i].a);
            set_reg(2'd2, vecs[i].b);
            load_ir({vecs[i].opc, 8'h09});
            chk($sformatf("vec%0d_dec", i), 64'(dec16), 64'(vecs[i].dec));
            alu_exec(vecs[i].op);
            chk($sformatf("vec%0d_zero", i), 64'(z16), 64'(vecs[i].z));
            chk($sformatf("vec%0d_neg", i), 64'(n16), 64'(vecs[i].n));
            chk($sformatf("vec%0d_uov", i), 64'(u16f), 64'(vecs[i].u));
            chk($sformatf("vec%0d_sov", i), 64'(s16), 64'(vecs[i].s));
            get_reg(2'd2, vecs[i].r16, vecs[i].r32);
        end

        // Store with held address/data, then load into reg2
        set_reg(2'd2, 64'h1234);
        load_ir(16'h825F);
        chk("store_dec", 64'(dec16), 64'(I_STORE));
        sb16.push_back(64'h1234);
        sb32.push_back(64'h1234);
        do_access(1'b1, 1'b1, 64'h0, 4, 1'b0, 1'b0, rc, a16, a32);
        chk("store_addr16", a16, 64'h1F);
        chk("store_addr32", a32, 64'h7);
        load_ir(16'h8140);
        acc(1'b0, 1'b1, 64'hBEEF);
        write_reg_enable = 1'b1; c_sel = 1'b0;
        @(negedge clk);
        write_reg_enable = 1'b0;
        get_reg(2'd2, 64'hBEEF, 64'hBEEF);

        // PC branch and wrap
        load_ir(16'h010A);
        chk("branch_dec", 64'(dec16), 64'(I_BRANCH));
        pulse_pc(1'b1);
        do_access(1'b0, 1'b0, 64'h0, 1, 1'b0, 1'b0, rc, a16, a32);
        chk("branch_pc16", a16, 64'h0A);
        chk("branch_pc32", a32, 64'h2);
        repeat (21) pulse_pc(1'b0);
        do_access(1'b0, 1'b0, 64'h0, 1, 1'b0, 1'b0, rc, a16, a32);
        chk("pc_max16", a16, 64'h1F);
        chk("pc_max32", a32, 64'h7);
        pulse_pc(1'b0);
        do_access(1'b0, 1'b0, 64'h0, 1, 1'b0, 1'b0, rc, a16, a32);
        chk("pc_wrap16", a16, 64'h0);
        chk("pc_wrap32", a32, 64'h0);
        do_access(1'b0, 1'b0, 64'h0, 2, 1'b1, 1'b0, rc, a16, a32);
        chk("same_cycle_old_pc", a16, 64'h0);
        do_access(1'b0, 1'b0, 64'h0, 1, 1'b0, 1'b0, rc, a16, a32);
        chk("same_cycle_new_pc", a16, 64'h1);

        // mem_start during REQ is ignored
        do_access(1'b0, 1'b0, 64'h0, 3, 1'b0, 1'b1, rc, a16, a32);
        chk("restart_req_cycles", 64'(rc), 64'h3);
        chk("restart_idle_busy", 64'(busy16), 64'h0);

        // ack while idle does nothing
        ack_drv = 1'b1; rd_val = 64'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ack_done", 64'(done16), 64'h0);
            chk("idle_ack_req", 64'(ram16.ram_req), 64'h0);
        end
        ack_drv = 1'b0; rd_val = '0;

        // Reset in the middle of a request
        acc(1'b0, 1'b0, 64'hA104);
        mem_start = 1'b1; mem_write = 1'b0; addr_sel = 1'b0;
        @(negedge clk);
        mem_start = 1'b0;
        chk("rst_mid_req_before", 64'(ram16.ram_req), 64'h1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_req_async", 64'(ram16.ram_req), 64'h0);
        chk("rst_mid_busy", 64'(busy16), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_drv = 1'b1; rd_val = 64'hA204;
        @(negedge clk);
        ack_drv = 1'b0; rd_val = '0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_mid_no_done", 64'(done16), 64'h0);
            chk("rst_mid_no_req", 64'(ram16.ram_req), 64'h0);
            @(negedge clk);
        end
        pulse_ir();
        chk("rst_mid_rdbuf_clear", 64'(dec16), 64'(I_NOP));

        // Wide-datapath carry out to zero
        set_reg(2'd0, 64'h1);
        set_reg(2'd1, 64'hFFFFFFFF);
        load_ir(16'hA104);
        alu_exec(ALU_ADD);
        chk("w32_zero", 64'(z32), 64'h1);
        chk("w32_uov", 64'(u32f), 64'h1);
        chk("w32_neg", 64'(n32), 64'h0);
        chk("w32_sov", 64'(s32), 64'h0);
        chk("w16_zero", 64'(z16), 64'h1);
        chk("w16_uov", 64'(u16f), 64'h1);
        get_reg(2'd1, 64'h0, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
